// File: rtl/mc_control_fsm.sv
// mc_control_fsm -- multicycle control unit for the MIPS datapath.
//
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB and drives
// the datapath mux selects, register/PC write strobes and memory requests.
// Outputs are combinational from the registered state plus opcode/funct.
//
// Ports:
//   CLK          clock, rising edge
//   RST          synchronous active-high reset (also forces outputs to defaults)
//   opcode/funct IR[31:26] / IR[5:0], valid from DECODE onward
//   zero         ALU zero flag, used only in EXEC for branches
//   ihit/dhit    instruction / data memory done
//   iren, ir_en  instruction read request, IR load (iren & ihit)
//   dren, dwen   data read / write request
//   pc_en        PC load, one per retired instruction
//   pc_sel       0=branch 1=jr 2=jump 3=npc
//   alu_b_sel    0=ext32 1=rf 2=shamt
//   alu_op       0=SLL 1=SRL 2=ADD 3=SUB 4=AND 5=OR 6=XOR 7=NOR 8=SLT 9=SLTU
//   ext_zero     1=zero-extend imm16
//   rf_wen       register write strobe
//   rf_dst_sel   0=rd 1=rt 2=r31
//   rf_wdat_sel  0=alu 1=imm16 2=npc 3=ram data
//   halt         sticky halt indicator
//   illegal      one-cycle pulse on unsupported opcode/funct
module mc_control_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       ihit,
  input  logic       dhit,
  output logic       iren,
  output logic       ir_en,
  output logic       dren,
  output logic       dwen,
  output logic       pc_en,
  output logic [1:0] pc_sel,
  output logic [1:0] alu_b_sel,
  output logic [3:0] alu_op,
  output logic       ext_zero,
  output logic       rf_wen,
  output logic [1:0] rf_dst_sel,
  output logic [1:0] rf_wdat_sel,
  output logic       halt,
  output logic       illegal
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [1:0] PC_BRANCH = 2'd0;
  localparam logic [1:0] PC_JRA    = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_NPC    = 2'd3;

  localparam logic [1:0] AB_EXT32 = 2'd0;
  localparam logic [1:0] AB_RF    = 2'd1;
  localparam logic [1:0] AB_SHAMT = 2'd2;

  localparam logic [1:0] RFW_ALUO    = 2'd0;
  localparam logic [1:0] RFW_IMM16   = 2'd1;
  localparam logic [1:0] RFW_NPC     = 2'd2;
  localparam logic [1:0] RFW_RAMDATA = 2'd3;

  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRL  = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  logic [2:0] state_reg;
  logic [2:0] state_next;

  // Instruction classification and the ALU controls used from EXEC onward.
  logic       is_legal, is_r, is_jr, is_beq, is_bne, is_lw, is_sw;
  logic       is_j, is_jal, is_lui, is_halt;
  logic [3:0] ex_alu_op;
  logic [1:0] ex_alu_b;
  logic       ex_ext_zero;

  always_comb begin
    is_legal    = 1'b1;
    is_r        = 1'b0;
    is_jr       = 1'b0;
    is_beq      = 1'b0;
    is_bne      = 1'b0;
    is_lw       = 1'b0;
    is_sw       = 1'b0;
    is_j        = 1'b0;
    is_jal      = 1'b0;
    is_lui      = 1'b0;
    is_halt     = 1'b0;
    ex_alu_op   = ALU_ADD;
    ex_alu_b    = AB_RF;
    ex_ext_zero = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        is_r = 1'b1;
        case (funct)
          6'h00: begin ex_alu_op = ALU_SLL; ex_alu_b = AB_SHAMT; end
          6'h02: begin ex_alu_op = ALU_SRL; ex_alu_b = AB_SHAMT; end
          6'h08: is_jr = 1'b1;
          6'h21: ex_alu_op = ALU_ADD;
          6'h23: ex_alu_op = ALU_SUB;
          6'h24: ex_alu_op = ALU_AND;
          6'h25: ex_alu_op = ALU_OR;
          6'h26: ex_alu_op = ALU_XOR;
          6'h27: ex_alu_op = ALU_NOR;
          6'h2A: ex_alu_op = ALU_SLT;
          6'h2B: ex_alu_op = ALU_SLTU;
          default: is_legal = 1'b0;
        endcase
      end
      OP_J:     is_j = 1'b1;
      OP_JAL:   is_jal = 1'b1;
      OP_BEQ:   begin is_beq = 1'b1; ex_alu_op = ALU_SUB; end
      OP_BNE:   begin is_bne = 1'b1; ex_alu_op = ALU_SUB; end
      OP_ADDIU: begin ex_alu_op = ALU_ADD;  ex_alu_b = AB_EXT32; end
      OP_SLTI:  begin ex_alu_op = ALU_SLT;  ex_alu_b = AB_EXT32; end
      OP_SLTIU: begin ex_alu_op = ALU_SLTU; ex_alu_b = AB_EXT32; end
      OP_ANDI:  begin ex_alu_op = ALU_AND; ex_alu_b = AB_EXT32; ex_ext_zero = 1'b1; end
      OP_ORI:   begin ex_alu_op = ALU_OR;  ex_alu_b = AB_EXT32; ex_ext_zero = 1'b1; end
      OP_XORI:  begin ex_alu_op = ALU_XOR; ex_alu_b = AB_EXT32; ex_ext_zero = 1'b1; end
      OP_LUI:   is_lui = 1'b1;
      OP_LW:    begin is_lw = 1'b1; ex_alu_b = AB_EXT32; end
      OP_SW:    begin is_sw = 1'b1; ex_alu_b = AB_EXT32; end
      OP_HALT:  is_halt = 1'b1;
      default:  is_legal = 1'b0;
    endcase
  end

  // Next state and outputs. Under RST everything stays at its default so a
  // reset mid-instruction drops requests and writes immediately.
  always_comb begin
    state_next  = state_reg;
    iren        = 1'b0;
    ir_en       = 1'b0;
    dren        = 1'b0;
    dwen        = 1'b0;
    pc_en       = 1'b0;
    rf_wen      = 1'b0;
    halt        = 1'b0;
    illegal     = 1'b0;
    pc_sel      = PC_NPC;
    alu_b_sel   = AB_RF;
    alu_op      = ALU_ADD;
    ext_zero    = 1'b0;
    rf_dst_sel  = 2'd0;
    rf_wdat_sel = RFW_ALUO;
    if (!RST) begin
      case (state_reg)
        S_FETCH: begin
          iren = 1'b1;
          if (ihit) begin
            ir_en      = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          if (!is_legal) begin
            illegal    = 1'b1;
            pc_en      = 1'b1;
            state_next = S_FETCH;
          end else if (is_j) begin
            pc_en      = 1'b1;
            pc_sel     = PC_JUMP;
            state_next = S_FETCH;
          end else if (is_jal || is_lui) begin
            state_next = S_WB;
          end else if (is_halt) begin
            state_next = S_HALT;
          end else begin
            state_next = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_op    = ex_alu_op;
          alu_b_sel = ex_alu_b;
          ext_zero  = ex_ext_zero;
          if (is_jr) begin
            pc_en      = 1'b1;
            pc_sel     = PC_JRA;
            state_next = S_FETCH;
          end else if (is_beq || is_bne) begin
            pc_en      = 1'b1;
            if (is_beq ? zero : !zero)
              pc_sel = PC_BRANCH;
            state_next = S_FETCH;
          end else if (is_lw || is_sw) begin
            state_next = S_MEM;
          end else begin
            state_next = S_WB;
          end
        end
        S_MEM: begin
          // Keep the address computation steady while the request is open.
          alu_op    = ex_alu_op;
          alu_b_sel = ex_alu_b;
          ext_zero  = ex_ext_zero;
          if (is_lw) begin
            dren = 1'b1;
            if (dhit)
              state_next = S_WB;
          end else begin
            dwen = 1'b1;
            if (dhit) begin
              pc_en      = 1'b1;
              state_next = S_FETCH;
            end
          end
        end
        S_WB: begin
          // JAL/LUI never set non-default ALU controls, so this is harmless.
          alu_op     = ex_alu_op;
          alu_b_sel  = ex_alu_b;
          ext_zero   = ex_ext_zero;
          rf_wen     = 1'b1;
          pc_en      = 1'b1;
          state_next = S_FETCH;
          if (is_jal) begin
            rf_dst_sel  = 2'd2;
            rf_wdat_sel = RFW_NPC;
            pc_sel      = PC_JUMP;
          end else if (is_lui) begin
            rf_dst_sel  = 2'd1;
            rf_wdat_sel = RFW_IMM16;
          end else if (is_lw) begin
            rf_dst_sel  = 2'd1;
            rf_wdat_sel = RFW_RAMDATA;
          end else if (!is_r) begin
            rf_dst_sel = 2'd1;
          end
        end
        S_HALT: halt = 1'b1;
        default: state_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      state_reg <= S_FETCH;
    else
      state_reg <= state_next;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed testbench for mc_control_fsm. Each scenario is a per-cycle table of
// inputs and expected strobes/selects; inputs change just after the falling
// edge and outputs are sampled 1 time unit later.
module tb_mc_control_fsm;

  logic       CLK, RST, zero, ihit, dhit;
  logic [5:0] opcode, funct;
  logic       iren, ir_en, dren, dwen, pc_en, ext_zero, rf_wen, halt, illegal;
  logic [1:0] pc_sel, alu_b_sel, rf_dst_sel, rf_wdat_sel;
  logic [3:0] alu_op;

  int total = 0;
  int bad   = 0;

  mc_control_fsm dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct), .zero(zero),
    .ihit(ihit), .dhit(dhit), .iren(iren), .ir_en(ir_en), .dren(dren),
    .dwen(dwen), .pc_en(pc_en), .pc_sel(pc_sel), .alu_b_sel(alu_b_sel),
    .alu_op(alu_op), .ext_zero(ext_zero), .rf_wen(rf_wen),
    .rf_dst_sel(rf_dst_sel), .rf_wdat_sel(rf_wdat_sel), .halt(halt),
    .illegal(illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // strobes: iren ir_en dren dwen pc_en rf_wen halt illegal
  logic [7:0]  stb;
  // selects: pc_sel alu_b_sel alu_op ext_zero rf_dst_sel rf_wdat_sel
  logic [12:0] sel;
  assign stb = {iren, ir_en, dren, dwen, pc_en, rf_wen, halt, illegal};
  assign sel = {pc_sel, alu_b_sel, alu_op, ext_zero, rf_dst_sel, rf_wdat_sel};

  typedef struct packed {
    logic        rst, ih, dh, zr;
    logic [5:0]  op, fn;
    logic [7:0]  stb;
    logic        cs;
    logic [12:0] sel;
  } vec_t;

  function automatic logic [12:0] sl(input logic [1:0] pc, input logic [1:0] ab,
                                     input logic [3:0] op, input logic ez,
                                     input logic [1:0] dst, input logic [1:0] wd);
    return {pc, ab, op, ez, dst, wd};
  endfunction

  function automatic vec_t cv(input logic r, input logic ih, input logic dh, input logic zr,
                              input logic [5:0] op, input logic [5:0] fn,
                              input logic [7:0] s, input logic cs, input logic [12:0] se);
    vec_t v;
    v.rst = r; v.ih = ih; v.dh = dh; v.zr = zr; v.op = op; v.fn = fn;
    v.stb = s; v.cs = cs; v.sel = se;
    return v;
  endfunction

  logic [12:0] sd;  // default selects
  initial sd = sl(2'd3, 2'd1, 4'd2, 1'b0, 2'd0, 2'd0);

  task automatic apply(input vec_t v);
    RST = v.rst; ihit = v.ih; dhit = v.dh; zero = v.zr; opcode = v.op; funct = v.fn;
  endtask

  task automatic test_reset;
    vec_t v[$];
    for (int i = 0; i < 3; i++) v.push_back(cv(1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 8'h80, 1'b1, sd));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]); #1;
      total++;
      if (stb !== v[i].stb) begin bad++; $display("FAIL reset c%0d strobes got=%b want=%b", i, stb, v[i].stb); end
      total++;
      if (sel !== v[i].sel) begin bad++; $display("FAIL reset c%0d selects got=%h want=%h", i, sel, v[i].sel); end
      @(negedge CLK);
    end
    $display("test_reset: %0d cycles", v.size());
  endtask

  task automatic test_rtype;
    vec_t v[$];
    // ADDU with two ihit wait cycles: 6 cycles total
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h21, 8'h80, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h21, 8'h80, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 6'h21, 8'hC0, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 6'h21, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h21, 8'h00, 1'b1, sl(2'd3, 2'd1, 4'd2, 1'b0, 2'd0, 2'd0)));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h21, 8'h0C, 1'b1, sl(2'd3, 2'd1, 4'd2, 1'b0, 2'd0, 2'd0)));
    // SLL uses the shift amount on port B
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 8'hC0, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 8'h00, 1'b1, sl(2'd3, 2'd2, 4'd0, 1'b0, 2'd0, 2'd0)));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 8'h0C, 1'b1, sl(2'd3, 2'd2, 4'd0, 1'b0, 2'd0, 2'd0)));
    // SLTU
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 6'h2B, 8'hC0, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h2B, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h2B, 8'h00, 1'b1, sl(2'd3, 2'd1, 4'd9, 1'b0, 2'd0, 2'd0)));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h2B, 8'h0C, 1'b1, sl(2'd3, 2'd1, 4'd9, 1'b0, 2'd0, 2'd0)));
    // JR retires in EXEC with PC_JRA
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 6'h08, 8'hC0, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h08, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h08, 8'h08, 1'b1, sl(2'd1, 2'd1, 4'd2, 1'b0, 2'd0, 2'd0)));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]); #1;
      total++;
      if (stb !== v[i].stb) begin bad++; $display("FAIL rtype c%0d strobes got=%b want=%b", i, stb, v[i].stb); end
      total++;
      if (sel !== v[i].sel) begin bad++; $display("FAIL rtype c%0d selects got=%h want=%h", i, sel, v[i].sel); end
      @(negedge CLK);
    end
    $display("test_rtype: %0d cycles", v.size());
  endtask

  task automatic test_branch;
    vec_t v[$];
    logic [5:0]  ops [4] = '{6'h04, 6'h05, 6'h04, 6'h05};
    logic        zs  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0]  pcs [4] = '{2'd0, 2'd3, 2'd3, 2'd0};
    for (int k = 0; k < 4; k++) begin
      v.push_back(cv(1'b0, 1'b1, 1'b0, zs[k], ops[k], 6'h00, 8'hC0, 1'b1, sd));
      v.push_back(cv(1'b0, 1'b0, 1'b0, zs[k], ops[k], 6'h00, 8'h00, 1'b1, sd));
      v.push_back(cv(1'b0, 1'b0, 1'b0, zs[k], ops[k], 6'h00, 8'h08, 1'b1, sl(pcs[k], 2'd1, 4'd3, 1'b0, 2'd0, 2'd0)));
    end
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]); #1;
      total++;
      if (stb !== v[i].stb) begin bad++; $display("FAIL branch c%0d strobes got=%b want=%b", i, stb, v[i].stb); end
      total++;
      if (sel !== v[i].sel) begin bad++; $display("FAIL branch c%0d selects got=%h want=%h", i, sel, v[i].sel); end
      @(negedge CLK);
    end
    $display("test_branch: %0d cycles", v.size());
  endtask

  task automatic test_mem;
    vec_t v[$];
    // LW, dhit after 3 wait cycles (dhit early is ignored): 8 cycles
    v.push_back(cv(1'b0, 1'b1, 1'b1, 1'b0, 6'h23, 6'h00, 8'hC0, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b1, 1'b0, 6'h23, 6'h00, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b1, 1'b0, 6'h23, 6'h00, 8'h00, 1'b1, sl(2'd3, 2'd0, 4'd2, 1'b0, 2'd0, 2'd0)));
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h23, 6'h00, 8'h20, 1'b0, sd));
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h23, 6'h00, 8'h20, 1'b0, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h23, 6'h00, 8'h20, 1'b0, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b1, 1'b0, 6'h23, 6'h00, 8'h20, 1'b0, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h23, 6'h00, 8'h0C, 1'b1, sl(2'd3, 2'd0, 4'd2, 1'b0, 2'd1, 2'd3)));
    // SW with zero-wait dhit: 4 cycles
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h2B, 6'h00, 8'hC0, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h2B, 6'h00, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h2B, 6'h00, 8'h00, 1'b1, sl(2'd3, 2'd0, 4'd2, 1'b0, 2'd0, 2'd0)));
    v.push_back(cv(1'b0, 1'b0, 1'b1, 1'b0, 6'h2B, 6'h00, 8'h18, 1'b0, sd));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]); #1;
      total++;
      if (stb !== v[i].stb) begin bad++; $display("FAIL mem c%0d strobes got=%b want=%b", i, stb, v[i].stb); end
      if (v[i].cs) begin
        total++;
        if (sel !== v[i].sel) begin bad++; $display("FAIL mem c%0d selects got=%h want=%h", i, sel, v[i].sel); end
      end
      @(negedge CLK);
    end
    $display("test_mem: %0d cycles", v.size());
  endtask

  task automatic test_jumps_imm;
    vec_t v[$];
    // J: 2 cycles
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h02, 6'h00, 8'hC0, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h02, 6'h00, 8'h08, 1'b1, sl(2'd2, 2'd1, 4'd2, 1'b0, 2'd0, 2'd0)));
    // JAL: 3 cycles
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h03, 6'h00, 8'hC0, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h03, 6'h00, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h03, 6'h00, 8'h0C, 1'b1, sl(2'd2, 2'd1, 4'd2, 1'b0, 2'd2, 2'd2)));
    // ORI: 4 cycles, zero-extended immediate
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h0D, 6'h00, 8'hC0, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h0D, 6'h00, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h0D, 6'h00, 8'h00, 1'b1, sl(2'd3, 2'd0, 4'd5, 1'b1, 2'd0, 2'd0)));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h0D, 6'h00, 8'h0C, 1'b1, sl(2'd3, 2'd0, 4'd5, 1'b1, 2'd1, 2'd0)));
    // SLTI: sign-extended immediate
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h0A, 6'h00, 8'hC0, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h0A, 6'h00, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h0A, 6'h00, 8'h00, 1'b1, sl(2'd3, 2'd0, 4'd8, 1'b0, 2'd0, 2'd0)));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h0A, 6'h00, 8'h0C, 1'b1, sl(2'd3, 2'd0, 4'd8, 1'b0, 2'd1, 2'd0)));
    // LUI: 3 cycles
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h0F, 6'h00, 8'hC0, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h0F, 6'h00, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h0F, 6'h00, 8'h0C, 1'b1, sl(2'd3, 2'd1, 4'd2, 1'b0, 2'd1, 2'd1)));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]); #1;
      total++;
      if (stb !== v[i].stb) begin bad++; $display("FAIL jumps_imm c%0d strobes got=%b want=%b", i, stb, v[i].stb); end
      total++;
      if (sel !== v[i].sel) begin bad++; $display("FAIL jumps_imm c%0d selects got=%h want=%h", i, sel, v[i].sel); end
      @(negedge CLK);
    end
    $display("test_jumps_imm: %0d cycles", v.size());
  endtask

  task automatic test_illegal;
    vec_t v[$];
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h3E, 6'h00, 8'hC0, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h3E, 6'h00, 8'h09, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 6'h01, 8'hC0, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h01, 8'h09, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h01, 8'h80, 1'b1, sd));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]); #1;
      total++;
      if (stb !== v[i].stb) begin bad++; $display("FAIL illegal c%0d strobes got=%b want=%b", i, stb, v[i].stb); end
      total++;
      if (sel !== v[i].sel) begin bad++; $display("FAIL illegal c%0d selects got=%h want=%h", i, sel, v[i].sel); end
      @(negedge CLK);
    end
    $display("test_illegal: %0d cycles", v.size());
  endtask

  task automatic test_halt;
    vec_t v[$];
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h3F, 6'h00, 8'hC0, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h3F, 6'h00, 8'h00, 1'b1, sd));
    for (int i = 0; i < 3; i++) v.push_back(cv(1'b0, 1'b1, 1'b1, 1'b0, 6'h3F, 6'h00, 8'h02, 1'b1, sd));
    v.push_back(cv(1'b1, 1'b1, 1'b0, 1'b0, 6'h3F, 6'h00, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h21, 8'h80, 1'b1, sd));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]); #1;
      total++;
      if (stb !== v[i].stb) begin bad++; $display("FAIL halt c%0d strobes got=%b want=%b", i, stb, v[i].stb); end
      total++;
      if (sel !== v[i].sel) begin bad++; $display("FAIL halt c%0d selects got=%h want=%h", i, sel, v[i].sel); end
      @(negedge CLK);
    end
    $display("test_halt: %0d cycles", v.size());
  endtask

  task automatic test_reset_mid;
    vec_t v[$];
    // reset while LW waits in MEM: request drops, restart in FETCH
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h23, 6'h00, 8'hC0, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h23, 6'h00, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h23, 6'h00, 8'h00, 1'b0, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h23, 6'h00, 8'h20, 1'b0, sd));
    v.push_back(cv(1'b1, 1'b0, 1'b0, 1'b0, 6'h23, 6'h00, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b1, 1'b0, 6'h23, 6'h00, 8'h80, 1'b1, sd));
    // reset during ADDU WB: no register write
    v.push_back(cv(1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 6'h21, 8'hC0, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h21, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h21, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h21, 8'h00, 1'b1, sd));
    v.push_back(cv(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h21, 8'h80, 1'b1, sd));
    for (int i = 0; i < v.size(); i++) begin
      apply(v[i]); #1;
      total++;
      if (stb !== v[i].stb) begin bad++; $display("FAIL reset_mid c%0d strobes got=%b want=%b", i, stb, v[i].stb); end
      if (v[i].cs) begin
        total++;
        if (sel !== v[i].sel) begin bad++; $display("FAIL reset_mid c%0d selects got=%h want=%h", i, sel, v[i].sel); end
      end
      @(negedge CLK);
    end
    $display("test_reset_mid: %0d cycles", v.size());
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b1; dhit = 1'b0; zero = 1'b0; opcode = 6'h00; funct = 6'h00;
    @(negedge CLK);
    test_reset;
    test_rtype;
    test_branch;
    test_mem;
    test_jumps_imm;
    test_illegal;
    test_halt;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
